// File: rtl/shift_req_fifo.sv
// ---------------------------------------------------------------------------
// shift_req_fifo
//
// Request queue in front of the barrel shifter. Each entry holds a shift
// opcode, a shift amount and an operand. Requests whose opcode is not a
// legal shift (1 SLL, 2 SRL, 3 ROR, 4 SRA, 5 ROL) are still handshaken.
// They are not stored, and err_cnt counts them (the count saturates at 255).
//
// Optional feature macro: SHIFT_FIFO_BYPASS_EN
//   When this macro is defined, a legal request that arrives while the queue
//   is empty and the consumer is ready goes straight to the outputs in the
//   same cycle. It is not written to storage. Without the macro, every
//   request is stored, so the minimum latency is a fixed one cycle.
//
// REG_WIDTH is taken from the shared ALU define `REG_WIDTH. If that define
// is not set, the width defaults to 32.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-high reset
//   in_valid     in   request offered
//   in_ready     out  request accepted when in_valid && in_ready
//   in_opsel     in   [2:0] shift opcode
//   in_amount    in   [4:0] shift amount
//   in_data      in   [REG_WIDTH-1:0] operand
//   out_valid    out  head entry present
//   out_ready    in   consumer takes the head when out_valid && out_ready
//   bs_opsel     out  [2:0] head opcode (zero when out_valid is low)
//   shift_amount out  [4:0] head amount (zero when out_valid is low)
//   data_in      out  [REG_WIDTH-1:0] head operand (zero when out_valid is low)
//   count        out  [4:0] occupancy
//   err_cnt      out  [7:0] dropped illegal requests, saturating
// ---------------------------------------------------------------------------
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module shift_req_fifo #(
    parameter int DEPTH     = 4,
    parameter int REG_WIDTH = `REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_opsel,
    input  logic [4:0]           in_amount,
    input  logic [REG_WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           bs_opsel,
    output logic [4:0]           shift_amount,
    output logic [REG_WIDTH-1:0] data_in,
    output logic [4:0]           count,
    output logic [7:0]           err_cnt
);

    localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

    // Storage: one array per field, indexed by the pointers.
    logic [2:0]           opsel_mem [DEPTH];
    logic [4:0]           amt_mem   [DEPTH];
    logic [REG_WIDTH-1:0] data_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [4:0]       count_reg, count_next;
    logic [7:0]       err_cnt_reg, err_cnt_next;

    logic             in_legal;
    logic             fifo_valid;
    logic             bypass;
    logic             accept;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_sel;

    assign in_legal   = (in_opsel >= 3'd1) && (in_opsel <= 3'd5);
    assign fifo_valid = (count_reg != 5'd0);

`ifdef SHIFT_FIFO_BYPASS_EN
    // The bypass path needs the consumer to be ready. If it is not ready,
    // the request is stored normally below.
    assign bypass = (count_reg == 5'd0) && in_valid && out_ready && in_legal;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = fifo_valid || bypass;

    // A full queue can still accept a request in the cycle it pops its head.
    assign in_ready = (count_reg < DEPTH_C) || (out_valid && out_ready);

    assign accept = in_valid && in_ready;
    assign push   = accept && in_legal && !bypass;
    assign pop    = fifo_valid && out_ready;

    // Head outputs: the bypassed request, the stored head, or zeros.
    always_comb begin
        bs_opsel     = '0;
        shift_amount = '0;
        data_in      = '0;
        if (bypass) begin
            bs_opsel     = in_opsel;
            shift_amount = in_amount;
            data_in      = in_data;
        end else if (fifo_valid) begin
            bs_opsel     = opsel_mem[rd_ptr_reg];
            shift_amount = amt_mem[rd_ptr_reg];
            data_in      = data_mem[rd_ptr_reg];
        end
    end

    // One-hot write select per entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // The storage has no reset. An entry only becomes visible through
    // count and rd_ptr, and reset clears both.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                opsel_mem[i] <= in_opsel;
                amt_mem[i]   <= in_amount;
                data_mem[i]  <= in_data;
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        err_cnt_next = err_cnt_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + 5'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 5'd1;
        end
        if (accept && !in_legal && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_cnt_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign count   = count_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_shift_req_fifo.sv
// ---------------------------------------------------------------------------
// tb_shift_req_fifo
//
// Directed testbench for shift_req_fifo with DEPTH=4 and REG_WIDTH=32.
// The stimulus is one linear sequence of steps. Every expected value is
// computed by hand or comes from a small shift reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_shift_req_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opsel;
    logic [4:0]  in_amount;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  bs_opsel;
    logic [4:0]  shift_amount;
    logic [31:0] data_in;
    logic [4:0]  count;
    logic [7:0]  err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_req_fifo #(.DEPTH(4), .REG_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opsel     (in_opsel),
        .in_amount    (in_amount),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bs_opsel     (bs_opsel),
        .shift_amount (shift_amount),
        .data_in      (data_in),
        .count        (count),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-18s observed=0x%08h expected=0x%08h ok", tag, obs, exp);
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then wait 1 ns so that sampling happens away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for a single cycle.
    task automatic push(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d);
        in_valid  = 1'b1;
        in_opsel  = op;
        in_amount = amt;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
    endtask

    // Reference barrel shifter.
    function automatic logic [31:0] shift_model(input logic [2:0] op, input logic [4:0] amt,
                                                input logic [31:0] d);
        logic [63:0] dd;
        dd = {d, d};
        case (op)
            3'd1:    return d << amt;
            3'd2:    return d >> amt;
            3'd3:    begin dd = dd >> amt; return dd[31:0];  end
            3'd4:    return 32'($signed(d) >>> amt);
            3'd5:    begin dd = dd << amt; return dd[63:32]; end
            default: return 32'd0;
        endcase
    endfunction

    // Wrap-around vectors: opcode, amount, operand, hand-computed result.
    logic [2:0]  w_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [4:0]  w_amt [5] = '{5'd4, 5'd8, 5'd4, 5'd4, 5'd8};
    logic [31:0] w_dat [5] = '{32'h12345678, 32'h80000001, 32'h12345678, 32'h80000000, 32'h12345678};
    logic [31:0] w_res [5] = '{32'h23456780, 32'h00800000, 32'h81234567, 32'hF8000000, 32'h34567812};

    initial begin
        logic [4:0] exp_amt [4];
        logic [2:0] illegal_ops [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opsel  = 3'd0;
        in_amount = 5'd0;
        in_data   = 32'd0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count",     32'(count),        32'd0);
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_err_cnt",   32'(err_cnt),      32'd0);
        check("rst_bs_opsel",  32'(bs_opsel),     32'd0);
        check("rst_data_in",   data_in,           32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),     32'd1);

        // Fill four entries while the consumer is stalled
        for (int i = 1; i <= 4; i++) begin
            push(3'd1, 5'(i), 32'hA5A5A5A5);
        end
        check("fill_count",    32'(count),        32'd4);
        check("fill_in_ready", 32'(in_ready),     32'd0);
        check("fill_head_amt", 32'(shift_amount), 32'd1);
        // The head must stay stable while the consumer is stalled.
        tick();
        check("stall_head_amt", 32'(shift_amount), 32'd1);

        // Drain the queue and check that entries come out in push order
        out_ready = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid",  32'(out_valid),    32'd1);
            check("drain_opsel",  32'(bs_opsel),     32'd1);
            check("drain_amount", 32'(shift_amount), 32'(i));
            check("drain_data",   data_in,           32'hA5A5A5A5);
            tick();
        end
        out_ready = 1'b0;
        #1;
        check("drain_count",   32'(count),        32'd0);
        check("drain_outv",    32'(out_valid),    32'd0);
        check("empty_amount",  32'(shift_amount), 32'd0);

        // Push and pop in the same cycle on a full queue
        for (int i = 0; i < 4; i++) begin
            push(3'd2, 5'(10 + i), 32'(i));
        end
        check("full_count",    32'(count),        32'd4);
        in_valid  = 1'b1;
        in_opsel  = 3'd3;
        in_amount = 5'd20;
        in_data   = 32'hDEADBEEF;
        out_ready = 1'b1;
        #1;
        check("simul_in_ready", 32'(in_ready),    32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("simul_count",   32'(count),        32'd4);
        check("simul_head",    32'(shift_amount), 32'd11);
        exp_amt = '{5'd11, 5'd12, 5'd13, 5'd20};
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("simul_drain",  32'(shift_amount), 32'(exp_amt[i]));
            tick();
        end
        check("simul_last_data", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Illegal opcodes are accepted but dropped
        illegal_ops = '{3'd0, 3'd6, 3'd7};
        for (int i = 0; i < 3; i++) begin
            push(illegal_ops[i], 5'd1, 32'h1);
        end
        check("illegal_count", 32'(count),        32'd0);
        check("illegal_err",   32'(err_cnt),      32'd3);
        check("illegal_outv",  32'(out_valid),    32'd0);
        in_valid = 1'b1;
        in_opsel = 3'd7;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("err_saturate",  32'(err_cnt),      32'd255);

        // Reset asserted mid-stream with three entries queued
        for (int i = 0; i < 3; i++) begin
            push(3'd5, 5'(i + 1), 32'h55);
        end
        check("pre_rst_count", 32'(count),        32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(count),        32'd0);
        check("mid_rst_outv",  32'(out_valid),    32'd0);
        check("mid_rst_err",   32'(err_cnt),      32'd0);
        check("mid_rst_opsel", 32'(bs_opsel),     32'd0);
        check("mid_rst_amt",   32'(shift_amount), 32'd0);
        check("mid_rst_data",  data_in,           32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rdy",  32'(in_ready),     32'd1);

        // Ten push/pop pairs, so that the pointers wrap twice
        for (int k = 0; k < 10; k++) begin
            int j;
            j = k % 5;
            out_ready = 1'b0;
            push(w_op[j], w_amt[j], w_dat[j]);
            check("wrap_valid",  32'(out_valid), 32'd1);
            check("wrap_data",   data_in,        w_dat[j]);
            check("wrap_result", shift_model(bs_opsel, shift_amount, data_in), w_res[j]);
            out_ready = 1'b1;
            tick();
            check("wrap_count",  32'(count),     32'd0);
        end
        out_ready = 1'b0;

        // Empty queue with a request offered and the consumer ready
        in_valid  = 1'b1;
        in_opsel  = 3'd1;
        in_amount = 5'd3;
        in_data   = 32'h00000001;
        out_ready = 1'b1;
        #1;
`ifdef SHIFT_FIFO_BYPASS_EN
        check("byp_outv_now",  32'(out_valid),    32'd1);
        check("byp_data_now",  data_in,           32'h00000001);
        tick();
        in_valid = 1'b0;
        #1;
        check("byp_count",     32'(count),        32'd0);
        check("byp_outv_after", 32'(out_valid),   32'd0);
`else
        check("nobyp_outv_now", 32'(out_valid),   32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check("nobyp_outv_next", 32'(out_valid),  32'd1);
        check("nobyp_count",   32'(count),        32'd1);
        check("nobyp_data",    data_in,           32'h00000001);
        tick();
        check("nobyp_drained", 32'(count),        32'd0);
`endif
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
